rx_ctrl_dec: RTL and testbench

RX_CTRL_DEC -- requirements
Module: rx_ctrl_dec

---
 rtl/rx_ctrl_dec.sv | 208 ++++++++++++++++++++
 tb/tb_rx_ctrl_dec.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rx_ctrl_dec.sv
// RS-485 command frame decoder: 8N1 byte receiver feeding an A5-framed command parser.
// Define RX_CKSUM_EN to require a sixth XOR checksum byte (dev^mod^addr^data).
`timescale 1ns/1ps
module rx_ctrl_dec #(
    parameter logic [15:0] CLK_DIV  = 16'd434,
    parameter logic [7:0]  DEV_ID   = 8'h01,
    parameter logic [7:0]  TMO_BITS = 8'd20
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       rx_ctrl,
    output logic [7:0] cmdr_dev,
    output logic [7:0] cmdr_mod,
    output logic [7:0] cmdr_addr,
    output logic [7:0] cmdr_data,
    output logic       cmdr_vld,
    output logic       rx_err
);

    localparam int unsigned CW = 16;
    localparam int unsigned TW = 32;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV >> 1) - CW'(1);
    localparam logic [CW-1:0] FULL_M1 = CLK_DIV - CW'(1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TMO_BITS) * TW'(CLK_DIV);
    localparam logic [7:0]    SOF     = 8'hA5;
    localparam logic [7:0]    BCAST   = 8'hFF;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
`ifdef RX_CKSUM_EN
    typedef enum logic [2:0] {F_HUNT, F_DEV, F_MOD, F_ADDR, F_DATA, F_CKS} fstate_t;
`else
    typedef enum logic [2:0] {F_HUNT, F_DEV, F_MOD, F_ADDR, F_DATA} fstate_t;
`endif

    logic          r_sync1, r_sync2, r_prev;
    bstate_t       r_bstate, w_bstate_nxt;
    logic [CW-1:0] r_bcnt, w_bcnt_nxt;
    logic [2:0]    r_bidx, w_bidx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          w_fall, w_byte_ok, w_stop_err;
    fstate_t       r_fstate, w_fstate_nxt;
    logic [7:0]    r_sh_dev, r_sh_mod, r_sh_addr;
    logic [7:0]    w_out_data;
    logic          w_ld_dev, w_ld_mod, w_ld_addr, w_ld_data;
    logic          w_accept, w_err, w_dev_hit, w_tmo;
    logic [TW-1:0] r_tmo_cnt;

    // Line synchronizer, presets to idle-high so reset release never fakes a start edge
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx_ctrl;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall = r_prev & ~r_sync2;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_bstate <= B_IDLE;
            r_bcnt   <= '0;
            r_bidx   <= '0;
            r_shift  <= '0;
        end else begin
            r_bstate <= w_bstate_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_bidx   <= w_bidx_nxt;
            r_shift  <= w_shift_nxt;
        end
    end

    // Bit FSM: start bit checked mid-bit, then one sample per bit period
    always_comb begin
        w_bstate_nxt = r_bstate;
        w_bcnt_nxt   = r_bcnt + CW'(1);
        w_bidx_nxt   = r_bidx;
        w_shift_nxt  = r_shift;
        w_byte_ok    = 1'b0;
        w_stop_err   = 1'b0;
        case (r_bstate)
            B_IDLE: begin
                w_bcnt_nxt = '0;
                if (w_fall) w_bstate_nxt = B_START;
            end
            B_START: begin
                if (r_bcnt == HALF_M1) begin
                    w_bcnt_nxt   = '0;
                    w_bidx_nxt   = '0;
                    w_bstate_nxt = r_sync2 ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (r_bcnt == FULL_M1) begin
                    w_bcnt_nxt  = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_bidx_nxt  = r_bidx + 3'd1;
                    if (r_bidx == 3'd7) w_bstate_nxt = B_STOP;
                end
            end
            B_STOP: begin
                if (r_bcnt == FULL_M1) begin
                    w_bcnt_nxt   = '0;
                    w_bstate_nxt = B_IDLE;
                    w_byte_ok    = r_sync2;
                    w_stop_err   = ~r_sync2;
                end
            end
            default: w_bstate_nxt = B_IDLE;
        endcase
    end

    // Inter-byte idle watchdog, armed only while a frame is in progress
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) r_tmo_cnt <= '0;
        else if (r_fstate != F_HUNT && r_bstate == B_IDLE && !w_tmo) r_tmo_cnt <= r_tmo_cnt + TW'(1);
        else r_tmo_cnt <= '0;
    end

    assign w_tmo     = (r_tmo_cnt == TMO_LIM);
    assign w_dev_hit = (r_sh_dev == DEV_ID) || (r_sh_dev == BCAST);

`ifdef RX_CKSUM_EN
    logic [7:0] r_sh_data;
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)         r_sh_data <= '0;
        else if (w_ld_data) r_sh_data <= r_shift;
    end
    assign w_out_data = r_sh_data;
`else
    assign w_out_data = r_shift;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_fstate  <= F_HUNT;
            r_sh_dev  <= '0;
            r_sh_mod  <= '0;
            r_sh_addr <= '0;
        end else begin
            r_fstate <= w_fstate_nxt;
            if (w_ld_dev)  r_sh_dev  <= r_shift;
            if (w_ld_mod)  r_sh_mod  <= r_shift;
            if (w_ld_addr) r_sh_addr <= r_shift;
        end
    end

    // Frame FSM: one state per good byte; errors always fall back to hunting
    always_comb begin
        w_fstate_nxt = r_fstate;
        w_ld_dev     = 1'b0;
        w_ld_mod     = 1'b0;
        w_ld_addr    = 1'b0;
        w_ld_data    = 1'b0;
        w_accept     = 1'b0;
        w_err        = 1'b0;
        if (w_stop_err || w_tmo) begin
            w_err        = 1'b1;
            w_fstate_nxt = F_HUNT;
        end else if (w_byte_ok) begin
            case (r_fstate)
                F_HUNT: if (r_shift == SOF) w_fstate_nxt = F_DEV;
                F_DEV:  begin w_ld_dev  = 1'b1; w_fstate_nxt = F_MOD;  end
                F_MOD:  begin w_ld_mod  = 1'b1; w_fstate_nxt = F_ADDR; end
                F_ADDR: begin w_ld_addr = 1'b1; w_fstate_nxt = F_DATA; end
`ifdef RX_CKSUM_EN
                F_DATA: begin w_ld_data = 1'b1; w_fstate_nxt = F_CKS;  end
                F_CKS: begin
                    w_fstate_nxt = F_HUNT;
                    if (r_shift == (r_sh_dev ^ r_sh_mod ^ r_sh_addr ^ r_sh_data)) w_accept = w_dev_hit;
                    else w_err = 1'b1;
                end
`else
                F_DATA: begin
                    w_fstate_nxt = F_HUNT;
                    w_accept     = w_dev_hit;
                end
`endif
                default: w_fstate_nxt = F_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cmdr_dev  <= '0;
            cmdr_mod  <= '0;
            cmdr_addr <= '0;
            cmdr_data <= '0;
            cmdr_vld  <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            cmdr_vld <= w_accept;
            rx_err   <= w_err;
            if (w_accept) begin
                cmdr_dev  <= r_sh_dev;
                cmdr_mod  <= r_sh_mod;
                cmdr_addr <= r_sh_addr;
                cmdr_data <= w_out_data;
            end
        end
    end

endmodule

// File: tb/tb_rx_ctrl_dec.sv
// Scoreboard bench for rx_ctrl_dec: stimulus pushes expected strobes, a monitor pops and compares.
`timescale 1ns/1ps
module tb_rx_ctrl_dec;

    localparam logic [15:0] DIV = 16'd8;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_ctrl = 1'b1;
    logic [7:0] cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data;
    logic       cmdr_vld, rx_err;

    typedef struct packed {
        logic       is_err;
        logic [7:0] dev;
        logic [7:0] md;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] last_dev = 8'h00, last_mod = 8'h00, last_addr = 8'h00, last_data = 8'h00;
    logic [31:0] prev_out = 32'h0;
    logic        prev_rst = 1'b0;

    rx_ctrl_dec #(.CLK_DIV(DIV), .DEV_ID(8'h01), .TMO_BITS(8'd20)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .rx_ctrl(rx_ctrl),
        .cmdr_dev(cmdr_dev), .cmdr_mod(cmdr_mod), .cmdr_addr(cmdr_addr),
        .cmdr_data(cmdr_data), .cmdr_vld(cmdr_vld), .rx_err(rx_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx_ctrl = v;
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        hold(1'b0, int'(DIV));
        for (int i = 0; i < 8; i++) hold(b[i], int'(DIV));
        hold(stop, int'(DIV));
        rx_ctrl = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] dv, input logic [7:0] md, input logic [7:0] ad,
                              input logic [7:0] da, input logic [7:0] ck);
        send_byte(8'hA5, 1'b1);
        send_byte(dv, 1'b1);
        send_byte(md, 1'b1);
        send_byte(ad, 1'b1);
        send_byte(da, 1'b1);
`ifdef RX_CKSUM_EN
        send_byte(ck, 1'b1);
`else
        if (ck == 8'h00) rx_ctrl = 1'b1;
`endif
    endtask

    task automatic expect_vld(input logic [7:0] dv, input logic [7:0] md, input logic [7:0] ad,
                              input logic [7:0] da);
        exp_q.push_back('{is_err: 1'b0, dev: dv, md: md, addr: ad, data: da});
        last_dev = dv; last_mod = md; last_addr = ad; last_data = da;
    endtask

    task automatic expect_err();
        exp_q.push_back('{is_err: 1'b1, dev: last_dev, md: last_mod, addr: last_addr, data: last_data});
    endtask

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clk_sys) begin
        ev_t e;
        if (rst_n && (cmdr_vld || rx_err)) begin
            check("vld_err_exclusive", 32'(cmdr_vld & rx_err), 32'h0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'({cmdr_vld, rx_err}), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(rx_err), 32'(e.is_err));
                check("cmdr_fields", {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data},
                      {e.dev, e.md, e.addr, e.data});
            end
        end
        if (rst_n && prev_rst && !cmdr_vld)
            check("cmdr_stable", {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data}, prev_out);
        prev_out = {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data};
        prev_rst = rst_n;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("reset_cmdr", {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data}, 32'h0);
        check("reset_strobes", 32'({cmdr_vld, rx_err}), 32'h0);
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
        hold(1'b1, 20);

        expect_vld(8'h01, 8'h10, 8'h20, 8'h33);
        send_frame(8'h01, 8'h10, 8'h20, 8'h33, 8'h02);
        hold(1'b1, 4);
        expect_vld(8'hFF, 8'h10, 8'h20, 8'h33);
        send_frame(8'hFF, 8'h10, 8'h20, 8'h33, 8'hFC);
        send_frame(8'h02, 8'h10, 8'h20, 8'h33, 8'h01);
        hold(1'b1, 4);
`ifdef RX_CKSUM_EN
        expect_err();
        send_frame(8'h01, 8'h10, 8'h20, 8'h33, 8'h00);
        hold(1'b1, 4);
`endif

        // Stop bit low on the module byte
        expect_err();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b0);
        hold(1'b1, 10);
        expect_vld(8'h01, 8'h44, 8'h55, 8'h66);
        send_frame(8'h01, 8'h44, 8'h55, 8'h66, 8'h76);

        // Short glitch, then a stalled frame
        hold(1'b1, 10);
        hold(1'b0, 2);
        hold(1'b1, 40);
        expect_err();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        hold(1'b1, 200);
        expect_vld(8'h01, 8'hAB, 8'hCD, 8'hEF);
        send_frame(8'h01, 8'hAB, 8'hCD, 8'hEF, 8'h88);

        // Back-to-back frames with no idle gap
        expect_vld(8'h01, 8'h12, 8'h34, 8'h56);
        expect_vld(8'hFF, 8'h9A, 8'hBC, 8'hDE);
        send_frame(8'h01, 8'h12, 8'h34, 8'h56, 8'h71);
        send_frame(8'hFF, 8'h9A, 8'hBC, 8'hDE, 8'h07);
        hold(1'b1, 10);

        // Reset mid-frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b1);
        hold(1'b1, 3);
        rst_n = 1'b0;
        hold(1'b1, 3);
        @(negedge clk_sys);
        check("midreset_cmdr", {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data}, 32'h0);
        check("midreset_strobes", 32'({cmdr_vld, rx_err}), 32'h0);
        @(posedge clk_sys); #1;
        last_dev = 8'h00; last_mod = 8'h00; last_addr = 8'h00; last_data = 8'h00;
        rst_n = 1'b1;
        hold(1'b1, 10);
        expect_vld(8'h01, 8'h10, 8'h20, 8'h33);
        send_frame(8'h01, 8'h10, 8'h20, 8'h33, 8'h02);

        hold(1'b1, 50);
        check("pending_expected", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
